shift_counter_ctrl: RTL and testbench

SHIFT_COUNTER_CTRL -- requirements
Module: shift_counter_ctrl

---
 rtl/shift_ctrl_pkg.sv | 23 ++
 rtl/shift_core.sv | 31 +++
 rtl/shift_counter_ctrl.sv | 96 +++++++++
 tb/tb_shift_counter_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/shift_ctrl_pkg.sv
// Shared types and helpers for the ring/Johnson shift-counter controller.
package shift_ctrl_pkg;

  typedef enum logic {
    RING    = 1'b0,
    JOHNSON = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int MAX_WIDTH = 16;

  // Ring starts from a single hot bit in the LSB, Johnson from all zeros.
  function automatic logic [MAX_WIDTH-1:0] seed_of(mode_e m);
    return (m == RING) ? MAX_WIDTH'(1) : '0;
  endfunction

endpackage

// File: rtl/shift_core.sv
// Shift register datapath: seeded load, then ring or Johnson rotation.
module shift_core
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             shift_en,
  input  mode_e            mode,
  output logic [WIDTH-1:0] Q
);

  logic feedback;

  // Johnson inverts the bit wrapping from MSB back to LSB.
  assign feedback = (mode == JOHNSON) ? ~Q[WIDTH-1] : Q[WIDTH-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Q <= WIDTH'(seed_of(RING));
    end else if (load) begin
      Q <= seed;
    end else if (shift_en) begin
      Q <= {Q[WIDTH-2:0], feedback};
    end
  end

endmodule

// File: rtl/shift_counter_ctrl.sv
// Sequencer that loads a seed and performs a counted number of shifts,
// with pause, abort and a sticky zero-step error flag.
//
// state | meaning
// IDLE  | waiting for start; Q holds last value
// LOAD  | seed Q and load remaining-step counter
// RUN   | one shift per unpaused cycle until rem reaches 1
// DONE  | single-cycle completion pulse
module shift_counter_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [CNT_W-1:0] steps,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] Q,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_e           state;
  mode_e            mode_q;
  logic [CNT_W-1:0] steps_q;
  logic [CNT_W-1:0] rem;
  logic             load;
  logic             shift_en;
  logic [WIDTH-1:0] seed;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      mode_q  <= RING;
      steps_q <= '0;
      rem     <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (steps != '0) begin
              mode_q  <= mode_e'(mode);
              steps_q <= steps;
              err     <= 1'b0;
              state   <= LOAD;
            end else begin
              err <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            rem   <= steps_q;
            state <= RUN;
          end
        end
        RUN: begin
          // Abort outranks both pause and the final shift.
          if (abort) begin
            state <= IDLE;
          end else if (!pause) begin
            rem <= rem - CNT_W'(1);
            if (rem == CNT_W'(1)) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign load     = (state == LOAD) && !abort;
  assign shift_en = (state == RUN) && !abort && !pause;
  assign seed     = WIDTH'(seed_of(mode_q));
  assign busy     = (state == LOAD) || (state == RUN);
  assign done     = (state == DONE);

  shift_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .seed     (seed),
    .shift_en (shift_en),
    .mode     (mode_q),
    .Q        (Q)
  );

endmodule

// File: tb/tb_shift_counter_ctrl.sv
// Bench for shift_counter_ctrl: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_shift_counter_ctrl;

  localparam int W  = 3;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic [CW-1:0] steps = '0;
  logic          pause = 1'b0;
  logic          abort = 1'b0;
  logic [W-1:0]  Q;
  logic          busy, done, err;

  int errors = 0;
  int checks = 0;

  shift_counter_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .mode  (mode),
    .steps (steps),
    .pause (pause),
    .abort (abort),
    .Q     (Q),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Q after k shifts from the seed, computed in closed form.
  function automatic logic [W-1:0] model_q(input logic md, input int k);
    int r;
    if (!md) begin
      r = k % W;
      return W'(1 << r);
    end
    r = k % (2 * W);
    if (r <= W) return W'((1 << r) - 1);
    return W'(((1 << (2 * W - r)) - 1) << (r - W));
  endfunction

  // Model phase: 0 idle, 1 loading, 2 running, 3 finished pulse.
  int           m_ph = 0;
  int           m_k = 0;
  int           m_left = 0;
  logic         m_mode = 1'b0;
  logic         m_err = 1'b0;
  logic [W-1:0] m_q = W'(1);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ph  = 0;
      m_q   = W'(1);
      m_err = 1'b0;
    end else begin
      case (m_ph)
        0: if (start) begin
          if (steps != 0) begin
            m_mode = mode;
            m_left = int'(steps);
            m_err  = 1'b0;
            m_ph   = 1;
          end else begin
            m_err = 1'b1;
          end
        end
        1: if (abort) m_ph = 0;
           else begin
             m_k  = 0;
             m_q  = model_q(m_mode, 0);
             m_ph = 2;
           end
        2: if (abort) m_ph = 0;
           else if (!pause) begin
             m_k++;
             m_left--;
             m_q = model_q(m_mode, m_k);
             if (m_left == 0) m_ph = 3;
           end
        default: m_ph = 0;
      endcase
    end
  end

  always @(posedge clk) begin
    #1;
    if (!reset) begin
      chk("q", 32'(Q), 32'(m_q));
      chk("busy", 32'(busy), 32'(m_ph == 1 || m_ph == 2));
      chk("done", 32'(done), 32'(m_ph == 3));
      chk("err", 32'(err), 32'(m_err));
    end
  end

  logic [W-1:0] cap[16];
  int dn, bz, didx;

  task automatic kick(input logic md, input int st);
    @(negedge clk);
    start = 1'b1;
    mode  = md;
    steps = CW'(st);
  endtask

  task automatic collect(input int n, input int p_on, input int p_off,
                         input int a_on, input int a_off);
    dn = 0; bz = 0; didx = -1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cap[i] = Q;
      if (done) begin dn++; didx = i; end
      if (busy) bz++;
      if (i == 0) start = 1'b0;
      if (i == p_on) pause = 1'b1;
      if (i == p_off) pause = 1'b0;
      if (i == a_on) abort = 1'b1;
      if (i == a_off) abort = 1'b0;
    end
  endtask

  logic [W-1:0] e_ring4[6] = '{3'b001, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
  logic [W-1:0] e_john6[7] = '{3'b000, 3'b001, 3'b011, 3'b111, 3'b110, 3'b100, 3'b000};

  initial begin
    #12;
    chk("reset_q", 32'(Q), 32'(3'b001));
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_done", 32'(done), 32'(0));
    chk("reset_err", 32'(err), 32'(0));
    @(negedge clk);
    reset = 1'b0;

    // Ring, 4 steps.
    kick(1'b0, 4);
    collect(8, -1, -1, -1, -1);
    for (int i = 0; i < 6; i++) chk($sformatf("ring4_q%0d", i), 32'(cap[i]), 32'(e_ring4[i]));
    chk("ring4_done_cnt", 32'(dn), 32'(1));
    chk("ring4_done_idx", 32'(didx), 32'(5));
    chk("ring4_final", 32'(cap[7]), 32'(3'b010));

    // Johnson, 6 steps: a full period back to zero.
    kick(1'b1, 6);
    collect(9, -1, -1, -1, -1);
    for (int i = 0; i < 7; i++) chk($sformatf("john6_q%0d", i), 32'(cap[i+1]), 32'(e_john6[i]));
    chk("john6_busy_cycles", 32'(bz), 32'(7));
    chk("john6_done_cnt", 32'(dn), 32'(1));
    chk("john6_done_idx", 32'(didx), 32'(7));

    // Zero-step start sets err, then a valid start clears it.
    kick(1'b0, 0);
    collect(3, -1, -1, -1, -1);
    chk("zero_err", 32'(err), 32'(1));
    chk("zero_busy", 32'(bz), 32'(0));
    chk("zero_done", 32'(dn), 32'(0));
    chk("zero_q_held", 32'(Q), 32'(3'b000));
    kick(1'b0, 2);
    collect(6, -1, -1, -1, -1);
    chk("restart_err", 32'(err), 32'(0));
    chk("restart_done_idx", 32'(didx), 32'(3));
    chk("restart_final", 32'(cap[5]), 32'(3'b100));

    // Pause for two cycles after the first shift delays done by two.
    kick(1'b0, 3);
    collect(10, 2, 4, -1, -1);
    chk("pause_done_idx", 32'(didx), 32'(6));
    chk("pause_done_cnt", 32'(dn), 32'(1));
    chk("pause_final", 32'(cap[9]), 32'(3'b001));

    // Abort on the final-shift cycle.
    kick(1'b0, 2);
    collect(6, -1, -1, 2, 3);
    chk("abort_done_cnt", 32'(dn), 32'(0));
    chk("abort_busy_cycles", 32'(bz), 32'(3));
    chk("abort_q_held", 32'(cap[5]), 32'(3'b010));
    kick(1'b1, 1);
    collect(4, -1, -1, -1, -1);
    chk("after_abort_done_idx", 32'(didx), 32'(2));
    chk("after_abort_q", 32'(cap[2]), 32'(3'b001));

    // Asynchronous reset between edges mid-run.
    kick(1'b0, 5);
    collect(3, -1, -1, -1, -1);
    @(posedge clk);
    #2;
    chk("pre_reset_q", 32'(Q), 32'(3'b100));
    #1;
    reset = 1'b1;
    #1;
    chk("async_q", 32'(Q), 32'(3'b001));
    chk("async_busy", 32'(busy), 32'(0));
    chk("async_done", 32'(done), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    collect(6, -1, -1, -1, -1);
    chk("post_reset_done", 32'(dn), 32'(0));
    chk("post_reset_busy", 32'(bz), 32'(0));

    // Randomized traffic, checked every cycle against the model.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      mode  = 1'($urandom);
      steps = ($urandom_range(0, 7) == 0) ? CW'(0) : CW'($urandom_range(1, 14));
      pause = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 19) == 0);
    end
    @(negedge clk);
    start = 1'b0; pause = 1'b0; abort = 1'b0;
    repeat (20) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
